// File: rtl/adc_capture_trigger.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture_trigger
// Brief    : Level-crossing trigger with decimated fixed-length capture and
//            post-capture holdoff, feeding a downstream SDRAM writer.
// Revision : 1.0 - initial release
// ============================================================================
module adc_capture_trigger #(
    parameter int ADC_WIDTH      = 12,
    parameter int CAPTURE_COUNT  = 128,
    parameter int HOLDOFF_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADC_WIDTH-1:0] adc_data,
    input  logic                 adc_valid,
    input  logic                 arm,
    input  logic [ADC_WIDTH-1:0] trig_level,
    input  logic                 trig_rising,
    input  logic [7:0]           decim,
    output logic                 start,
    output logic [15:0]          data_out,
    output logic                 data_valid,
    output logic                 busy,
    output logic [15:0]          sample_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    localparam int c_hold_w = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [c_hold_w-1:0] c_hold_last =
        c_hold_w'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);
    localparam logic [15:0] c_cap_count = 16'(CAPTURE_COUNT);
    localparam state_t c_after_capture = (HOLDOFF_CYCLES == 0) ? ST_IDLE : ST_HOLDOFF;
    localparam state_t c_after_trigger = (CAPTURE_COUNT <= 1) ? c_after_capture : ST_CAPTURE;

    state_t                r_state;
    logic [ADC_WIDTH-1:0]  r_prev;
    logic                  r_prev_valid;
    logic [7:0]            r_decim;
    logic [7:0]            r_decim_cnt;
    logic [c_hold_w-1:0]   r_hold_cnt;
    logic                  r_start;
    logic [15:0]           r_data_out;
    logic                  r_data_valid;
    logic [15:0]           r_sample_count;

    logic                  w_cross_rise;
    logic                  w_cross_fall;
    logic                  w_trigger;
    logic                  w_emit;
    logic                  w_last;
    logic [15:0]           w_data_ext;

    assign w_cross_rise = (r_prev < trig_level) && (adc_data >= trig_level);
    assign w_cross_fall = (r_prev >= trig_level) && (adc_data < trig_level);
    // The first sample after arming only primes r_prev, so it can never trigger.
    assign w_trigger    = adc_valid && r_prev_valid &&
                          (trig_rising ? w_cross_rise : w_cross_fall);
    assign w_emit       = adc_valid && (r_decim_cnt == r_decim);
    assign w_last       = ((r_sample_count + 16'd1) == c_cap_count);
    assign w_data_ext   = 16'(adc_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_prev         <= '0;
            r_prev_valid   <= 1'b0;
            r_decim        <= 8'd0;
            r_decim_cnt    <= 8'd0;
            r_hold_cnt     <= '0;
            r_start        <= 1'b1;
            r_data_out     <= 16'd0;
            r_data_valid   <= 1'b0;
            r_sample_count <= 16'd0;
        end else begin
            r_start      <= 1'b1;
            r_data_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (arm) begin
                        r_state      <= ST_ARMED;
                        r_prev_valid <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (adc_valid) begin
                        r_prev       <= adc_data;
                        r_prev_valid <= 1'b1;
                    end
                    // A trigger coinciding with arm dropping still starts a capture.
                    if (w_trigger) begin
                        r_state        <= c_after_trigger;
                        r_start        <= 1'b0;
                        r_data_out     <= w_data_ext;
                        r_data_valid   <= 1'b1;
                        r_sample_count <= 16'd1;
                        r_decim        <= decim;
                        r_decim_cnt    <= 8'd0;
                        r_hold_cnt     <= '0;
                    end else if (!arm) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CAPTURE: begin
                    if (w_emit) begin
                        r_decim_cnt    <= 8'd0;
                        r_data_out     <= w_data_ext;
                        r_data_valid   <= 1'b1;
                        r_sample_count <= r_sample_count + 16'd1;
                        if (w_last) begin
                            r_state    <= c_after_capture;
                            r_hold_cnt <= '0;
                        end
                    end else if (adc_valid) begin
                        r_decim_cnt <= r_decim_cnt + 8'd1;
                    end
                end
                ST_HOLDOFF: begin
                    if (r_hold_cnt == c_hold_last) begin
                        r_state    <= ST_IDLE;
                        r_hold_cnt <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign start        = r_start;
    assign data_out     = r_data_out;
    assign data_valid   = r_data_valid;
    assign sample_count = r_sample_count;
    assign busy         = (r_state == ST_CAPTURE) || (r_state == ST_HOLDOFF);

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_trigger.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_capture_trigger
// Brief    : Self-checking bench for adc_capture_trigger against a
//            transaction-level capture model, directed plus random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_capture_trigger;

    localparam int c_cap  = 128;
    localparam int c_hold = 256;

    logic        clk;
    logic        reset;
    logic [11:0] adc_data;
    logic        adc_valid;
    logic        arm;
    logic [11:0] trig_level;
    logic        trig_rising;
    logic [7:0]  decim;
    logic        start;
    logic [15:0] data_out;
    logic        data_valid;
    logic        busy;
    logic [15:0] sample_count;

    adc_capture_trigger #(
        .ADC_WIDTH      (12),
        .CAPTURE_COUNT  (c_cap),
        .HOLDOFF_CYCLES (c_hold)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .arm          (arm),
        .trig_level   (trig_level),
        .trig_rising  (trig_rising),
        .decim        (decim),
        .start        (start),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .busy         (busy),
        .sample_count (sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int start_q[$];
    int dv_q[$];
    int first_data;

    // Reference model: a capture is a run of valid samples indexed from the
    // trigger sample; index k is emitted when k is a multiple of decim+1.
    bit          m_search;
    bit          m_have_prev;
    logic [11:0] m_prev;
    int          m_cap_idx;
    int          m_cap_decim;
    int          m_hold_left;
    logic        e_start;
    logic        e_dv;
    logic [15:0] e_data;
    int          e_count;
    logic        e_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_search    = 0;
        m_have_prev = 0;
        m_prev      = '0;
        m_cap_idx   = -1;
        m_cap_decim = 0;
        m_hold_left = 0;
        e_start     = 1'b1;
        e_dv        = 1'b0;
        e_data      = 16'd0;
        e_count     = 0;
        e_busy      = 1'b0;
    endtask

    task automatic model_emit(input logic [11:0] d);
        e_dv   = 1'b1;
        e_data = {4'b0000, d};
        e_count++;
        if (e_count == c_cap) begin
            m_cap_idx   = -1;
            m_hold_left = c_hold;
        end
    endtask

    task automatic model_step(input logic v, input logic [11:0] d, input logic a,
                              input logic [11:0] lvl, input logic rise, input logic [7:0] dc);
        bit hit;
        e_start = 1'b1;
        e_dv    = 1'b0;
        hit     = 0;
        if (m_cap_idx >= 0) begin
            if (v) begin
                m_cap_idx++;
                if (m_cap_idx % (m_cap_decim + 1) == 0) model_emit(d);
            end
        end else if (m_hold_left > 0) begin
            m_hold_left--;
        end else if (m_search) begin
            if (v) begin
                if (m_have_prev)
                    hit = rise ? (m_prev < lvl && d >= lvl) : (m_prev >= lvl && d < lvl);
                m_prev      = d;
                m_have_prev = 1;
            end
            if (hit) begin
                m_search    = 0;
                e_start     = 1'b0;
                m_cap_idx   = 0;
                m_cap_decim = int'(dc);
                e_count     = 0;
                model_emit(d);
            end else if (!a) begin
                m_search = 0;
            end
        end else if (a) begin
            m_search    = 1;
            m_have_prev = 0;
        end
        e_busy = (m_cap_idx >= 0) || (m_hold_left > 0);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".start"},        32'(start),        32'(e_start));
        chk({tag, ".data_valid"},   32'(data_valid),   32'(e_dv));
        chk({tag, ".data_out"},     32'(data_out),     32'(e_data));
        chk({tag, ".busy"},         32'(busy),         32'(e_busy));
        chk({tag, ".sample_count"}, 32'(sample_count), 32'(e_count));
    endtask

    task automatic cycle(input string tag, input logic v, input logic [11:0] d,
                         input logic a, input logic [7:0] dc);
        adc_valid = v;
        adc_data  = d;
        arm       = a;
        decim     = dc;
        @(posedge clk);
        model_step(v, d, a, trig_level, trig_rising, dc);
        #1;
        cyc++;
        check_outputs(tag);
        if (start === 1'b0) start_q.push_back(cyc);
        if (data_valid === 1'b1) begin
            if (dv_q.size() == 0) first_data = int'(data_out);
            dv_q.push_back(cyc);
        end
    endtask

    task automatic clear_stats();
        start_q.delete();
        dv_q.delete();
        first_data = -1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle("drain", 1'b0, 12'd0, 1'b0, 8'd0);
    endtask

    initial begin
        reset       = 1'b1;
        adc_valid   = 1'b0;
        adc_data    = '0;
        arm         = 1'b0;
        trig_level  = '0;
        trig_rising = 1'b1;
        decim       = '0;
        model_reset();
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        reset = 1'b0;

        // Rising ramp through 2048
        trig_level  = 12'd2048;
        trig_rising = 1'b1;
        clear_stats();
        cycle("rise", 1'b0, 12'd0, 1'b1, 8'd0);
        for (int i = 0; i < 140; i++)
            cycle("rise", 1'b1, (i == 0) ? 12'd2000 : (i == 1) ? 12'd2040 : 12'(2050 + 10 * (i - 2)),
                  1'b1, 8'd0);
        idle_cycles(270);
        chk("rise_start_pulses", start_q.size(), 1);
        chk("rise_first_data",   first_data, 2050);
        chk("rise_dv_pulses",    dv_q.size(), 128);
        chk("rise_final_count",  32'(sample_count), 128);

        // Falling trigger; first sample already below level must not fire
        trig_level  = 12'd1000;
        trig_rising = 1'b0;
        clear_stats();
        cycle("fall", 1'b0, 12'd0, 1'b1, 8'd0);
        cycle("fall", 1'b1, 12'd900, 1'b1, 8'd0);
        chk("fall_no_first_trig", start_q.size(), 0);
        cycle("fall", 1'b1, 12'd1200, 1'b1, 8'd0);
        cycle("fall", 1'b1, 12'd900, 1'b1, 8'd0);
        chk("fall_start_at_cross", start_q.size(), 1);
        for (int i = 0; i < 130; i++) cycle("fall", 1'b1, 12'($urandom_range(0, 4095)), 1'b0, 8'd0);
        idle_cycles(270);
        chk("fall_start_pulses", start_q.size(), 1);
        chk("fall_dv_pulses",    dv_q.size(), 128);

        // Decimation by 4
        trig_level  = 12'd2048;
        trig_rising = 1'b1;
        clear_stats();
        cycle("decim", 1'b0, 12'd0, 1'b1, 8'd3);
        cycle("decim", 1'b1, 12'd1000, 1'b1, 8'd3);
        cycle("decim", 1'b1, 12'd3000, 1'b1, 8'd3);
        for (int i = 0; i < 520; i++) cycle("decim", 1'b1, 12'($urandom_range(0, 4095)), 1'b0, 8'(i % 5));
        idle_cycles(270);
        chk("decim_dv_pulses", dv_q.size(), 128);
        if (dv_q.size() == 128 && start_q.size() == 1)
            chk("decim_span", dv_q[127] - start_q[0] + 1, 509);
        else
            chk("decim_span_valid", 0, 1);

        // Holdoff with arm held and repeated crossings
        clear_stats();
        for (int i = 0; i < 700; i++)
            cycle("hold", 1'b1, (i % 2 == 0) ? 12'd2000 : 12'd2100, 1'b1, 8'd0);
        idle_cycles(400);
        chk("hold_restart", 32'(start_q.size() >= 2), 1);
        if (start_q.size() >= 2 && dv_q.size() >= 128)
            chk("hold_gap", 32'((start_q[1] - dv_q[127]) >= 259), 1);

        // Arm dropped in ARMED returns to IDLE without a start
        clear_stats();
        cycle("abort", 1'b0, 12'd0, 1'b1, 8'd0);
        cycle("abort", 1'b1, 12'd2000, 1'b1, 8'd0);
        cycle("abort", 1'b0, 12'd0, 1'b0, 8'd0);
        cycle("abort", 1'b1, 12'd2100, 1'b0, 8'd0);
        cycle("abort", 1'b1, 12'd2000, 1'b0, 8'd0);
        cycle("abort", 1'b1, 12'd2100, 1'b0, 8'd0);
        chk("abort_no_start", start_q.size(), 0);

        // Trigger coincident with arm falling, then reset after 40 samples
        clear_stats();
        cycle("rst", 1'b0, 12'd0, 1'b1, 8'd0);
        cycle("rst", 1'b1, 12'd2000, 1'b1, 8'd0);
        cycle("rst", 1'b1, 12'd2100, 1'b0, 8'd0);
        chk("trig_beats_disarm", start_q.size(), 1);
        for (int i = 0; i < 39; i++) cycle("rst", 1'b1, 12'($urandom_range(0, 4095)), 1'b0, 8'd0);
        chk("rst_pre_count", 32'(sample_count), 40);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs("async_reset");
        @(posedge clk);
        #1;
        check_outputs("reset_held");
        reset = 1'b0;
        clear_stats();
        for (int i = 0; i < 60; i++)
            cycle("post_rst", 1'b1, (i % 2 == 0) ? 12'd2000 : 12'd2100, 1'b0, 8'd0);
        chk("post_rst_no_start", start_q.size(), 0);
        chk("post_rst_no_dv",    dv_q.size(), 0);

        // Randomised traffic around a moving threshold
        clear_stats();
        for (int blk = 0; blk < 15; blk++) begin
            trig_level  = 12'($urandom_range(200, 3800));
            trig_rising = 1'($urandom_range(0, 1));
            for (int i = 0; i < 1000; i++)
                cycle("rand", 1'($urandom_range(0, 3) != 0),
                      12'(int'(trig_level) + $urandom_range(0, 200) - 100),
                      1'($urandom_range(0, 15) != 0), 8'($urandom_range(0, 2)));
        end
        chk("rand_saw_triggers", 32'(start_q.size() > 0), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
